// File: rtl/square_fixed.sv
// Iterative unsigned fixed-point squarer, Y = X*X, one shift-add step per clock.
// Define SQUARE_FIXED_ROUND_EN for round-half-up on dropped bits; otherwise the result truncates.
module square_fixed #(
   parameter int X_INT_B = 8,
   parameter int X_FP_B  = 3,
   parameter int Y_FP_B  = 3
) (
   input  logic                           clk,
   input  logic                           rst_,
   input  logic [X_INT_B+X_FP_B-1:0]      X,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic [2*X_INT_B+Y_FP_B-1:0]    Y
);

   localparam int XW = X_INT_B + X_FP_B;
   localparam int YW = 2*X_INT_B + Y_FP_B;
   localparam int D  = 2*X_FP_B - Y_FP_B;
   localparam int AW = 2*XW;
   localparam int CW = (XW > 1) ? $clog2(XW) : 1;

   // The shift amount is clamped so the unused branch stays legal when D is 0.
`ifdef SQUARE_FIXED_ROUND_EN
   localparam logic [AW-1:0] RND = (D > 0) ? (AW'(1) << ((D > 0) ? D-1 : 0)) : '0;
`else
   localparam logic [AW-1:0] RND = '0;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, MUL, NORM} state_t;

   state_t         state;
   logic [XW-1:0]  x_q;
   logic [XW-1:0]  mplier;
   logic [AW-1:0]  mcand;
   logic [AW-1:0]  acc;
   logic [CW-1:0]  cnt;
   logic [AW-1:0]  partial;
   logic [AW-1:0]  acc_rnd;

   assign partial = mplier[0] ? (mcand << cnt) : '0;
   assign acc_rnd = acc + RND;

   // Control and datapath share one register block; outputs are all registered.
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state  <= IDLE;
         x_q    <= '0;
         mplier <= '0;
         mcand  <= '0;
         acc    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         Y      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x_q   <= X;
                  state <= LOAD;
               end
            end
            LOAD: begin
               mcand  <= AW'(x_q);
               mplier <= x_q;
               acc    <= '0;
               cnt    <= '0;
               busy   <= 1'b1;
               state  <= MUL;
            end
            MUL: begin
               acc    <= acc + partial;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(XW-1)) begin
                  state <= NORM;
               end
            end
            NORM: begin
               Y     <= YW'(acc_rnd >> D);
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_square_fixed.sv
// Self-checking bench for square_fixed against an arithmetic model of X*X scaled to Y.
module tb_square_fixed;

   localparam int X_INT_B = 8;
   localparam int X_FP_B  = 3;
   localparam int Y_FP_B  = 3;
   localparam int XW      = X_INT_B + X_FP_B;
   localparam int YW      = 2*X_INT_B + Y_FP_B;
   localparam int DROP    = 2*X_FP_B - Y_FP_B;
   localparam int LAT     = XW + 2;

   logic          clk = 1'b0;
   logic          rst_;
   logic          start;
   logic [XW-1:0] X;
   logic          busy;
   logic          done;
   logic [YW-1:0] Y;

   int n_checks = 0;
   int n_fail   = 0;

   square_fixed #(.X_INT_B(X_INT_B), .X_FP_B(X_FP_B), .Y_FP_B(Y_FP_B)) dut (
      .clk   (clk),
      .rst_  (rst_),
      .X     (X),
      .start (start),
      .busy  (busy),
      .done  (done),
      .Y     (Y)
   );

   always #5 clk = ~clk;

   function automatic logic [YW-1:0] model_y(input logic [XW-1:0] x);
      longint unsigned p;
      longint unsigned rnd;
      p   = longint'(x) * longint'(x);
      rnd = 0;
`ifdef SQUARE_FIXED_ROUND_EN
      if (DROP > 0) rnd = longint'(1) << (DROP - 1);
`endif
      return YW'((p + rnd) >> DROP);
   endfunction

   // One transaction: start for a single edge, then count cycles until done.
   task automatic run_op(input logic [XW-1:0] x, output int lat, output int busy_cycles,
                         output logic [YW-1:0] y);
      @(negedge clk);
      X = x;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      busy_cycles = 0;
      y = '0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (busy) busy_cycles++;
         if (done) begin
            lat = k;
            y = Y;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int lat, bc, seen;
      logic [YW-1:0] y;
      rst_ = 1'b1;
      start = 1'b0;
      X = '0;
      #12;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %0b want 0", done); end
      n_checks++; if (Y !== '0) begin n_fail++; $display("[TB] FAIL reset_y got %0d want 0", Y); end
      @(negedge clk);
      rst_ = 1'b0;
      run_op(XW'(24), lat, bc, y);
      n_checks++; if (y !== YW'(72)) begin n_fail++; $display("[TB] FAIL pre_reset_y got %0d want 72", y); end
      // Abort a second operation in the middle of the multiply phase.
      @(negedge clk);
      X = XW'(24);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_mul_busy got %0b want 1", busy); end
      rst_ = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL async_rst_busy got %0b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL async_rst_done got %0b want 0", done); end
      n_checks++; if (Y !== '0) begin n_fail++; $display("[TB] FAIL async_rst_y got %0d want 0", Y); end
      @(negedge clk);
      rst_ = 1'b0;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("[TB] FAIL aborted_done got %0d pulses want 0", seen); end
      run_op(XW'(24), lat, bc, y);
      n_checks++; if (lat != LAT) begin n_fail++; $display("[TB] FAIL post_reset_lat got %0d want %0d", lat, LAT); end
      n_checks++; if (y !== YW'(72)) begin n_fail++; $display("[TB] FAIL post_reset_y got %0d want 72", y); end
   endtask

   task automatic test_corners();
      int lat, bc;
      logic [YW-1:0] y;
      logic [XW-1:0] xs [4];
      xs[0] = XW'(24);
      xs[1] = XW'(2);
      xs[2] = {XW{1'b1}};
      xs[3] = XW'(1);
      for (int i = 0; i < 4; i++) begin
         run_op(xs[i], lat, bc, y);
         n_checks++;
         if (y !== model_y(xs[i]) || lat != LAT) begin
            n_fail++;
            $display("[TB] FAIL corner_x%0d got y=%0d lat=%0d want y=%0d lat=%0d", xs[i], y, lat, model_y(xs[i]), LAT);
         end
      end
      run_op({XW{1'b1}}, lat, bc, y);
      n_checks++; if (y !== YW'(523776)) begin n_fail++; $display("[TB] FAIL full_scale got %0d want 523776", y); end
   endtask

   task automatic test_zero_latency();
      int lat, bc;
      logic [YW-1:0] y;
      run_op(XW'(24), lat, bc, y);
      run_op('0, lat, bc, y);
      n_checks++; if (y !== '0) begin n_fail++; $display("[TB] FAIL zero_y got %0d want 0", y); end
      n_checks++; if (lat != LAT) begin n_fail++; $display("[TB] FAIL zero_lat got %0d want %0d", lat, LAT); end
      n_checks++; if (bc != LAT - 1) begin n_fail++; $display("[TB] FAIL zero_busy_cycles got %0d want %0d", bc, LAT-1); end
   endtask

   task automatic test_random();
      int lat, bc;
      logic [YW-1:0] y;
      logic [XW-1:0] x;
      for (int i = 0; i < 10; i++) begin
         x = XW'($urandom_range(0, (1 << XW) - 1));
         run_op(x, lat, bc, y);
         n_checks++;
         if (y !== model_y(x) || lat != LAT) begin
            n_fail++;
            $display("[TB] FAIL random_x%0d got y=%0d lat=%0d want y=%0d lat=%0d", x, y, lat, model_y(x), LAT);
         end
      end
   endtask

   task automatic test_handshake();
      int lat, extra;
      logic [YW-1:0] y;
      @(negedge clk);
      X = XW'(24);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      y = '0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         start = (k == 2);
         if (k == 2) X = XW'(5);
         if (done) begin
            lat = k;
            y = Y;
            break;
         end
      end
      start = 1'b0;
      n_checks++; if (lat != LAT) begin n_fail++; $display("[TB] FAIL busy_start_lat got %0d want %0d", lat, LAT); end
      n_checks++; if (y !== YW'(72)) begin n_fail++; $display("[TB] FAIL busy_start_y got %0d want 72", y); end
      extra = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done) extra++;
      end
      n_checks++; if (extra != 0) begin n_fail++; $display("[TB] FAIL busy_start_queued got %0d pulses want 0", extra); end
   endtask

   task automatic test_back_to_back();
      int first_at, second_at;
      logic [YW-1:0] y1, y2;
      @(negedge clk);
      X = XW'(24);
      start = 1'b1;
      @(posedge clk);
      first_at = 0;
      second_at = 0;
      y1 = '0;
      y2 = '0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) X = XW'(100);
         if (k == LAT + 1) start = 1'b0;
         if (done && first_at == 0) begin
            first_at = k;
            y1 = Y;
         end else if (done && second_at == 0) begin
            second_at = k;
            y2 = Y;
            break;
         end
      end
      start = 1'b0;
      n_checks++; if (first_at != LAT || y1 !== YW'(72)) begin n_fail++; $display("[TB] FAIL b2b_first got at=%0d y=%0d want at=%0d y=72", first_at, y1, LAT); end
      n_checks++; if (second_at != 2*LAT + 1) begin n_fail++; $display("[TB] FAIL b2b_second_at got %0d want %0d", second_at, 2*LAT+1); end
      n_checks++; if (y2 !== model_y(XW'(100))) begin n_fail++; $display("[TB] FAIL b2b_second_y got %0d want %0d", y2, model_y(XW'(100))); end
   endtask

   initial begin
      test_reset();
      test_corners();
      test_zero_latency();
      test_random();
      test_handshake();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
